uart_boot_loader: RTL and testbench

Serial boot loader that sits directly upstream of the CPU top level and feeds its external data-memory write port. It receives an 8N1 UART byte stream, assembles little-endian 32-bit words and writes them to consecutive data-memory addresses through `Ext_MemWrite`/`Ext_WriteData`/`Ext_DataAdr`. While loading, it holds the CPU in reset through `cpu_reset`, and releases the CPU once the announced word count has been written.

---
 rtl/uart_boot_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
// uart_boot_loader : 8N1 UART receiver feeding little-endian words into the
//                    CPU data memory while holding the CPU in reset.
// Revision 1.0
// ============================================================================
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        frame_err
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rxState_t;

  typedef enum logic [1:0] {
    LD_LEN  = 2'd0,
    LD_DATA = 2'd1,
    LD_DONE = 2'd2
  } ldState_t;

  // Receiver
  logic               r_rxMeta;
  logic               r_rxSync;
  rxState_t           r_rxState;
  rxState_t           w_rxNext;
  logic [c_CNT_W-1:0] r_bitCnt;
  logic [2:0]         r_bitIdx;
  logic [7:0]         r_rxShift;
  logic               r_frameErr;
  logic               w_cntClr;
  logic               w_sampleBit;
  logic               w_byteValid;
  logic               w_frameErrSet;
  logic               w_halfDone;
  logic               w_bitDone;

  // Loader
  ldState_t           r_ldState;
  ldState_t           w_ldNext;
  logic [1:0]         r_byteCnt;
  logic [31:0]        r_wordShift;
  logic [31:0]        r_wordCount;
  logic [29:0]        r_wordIdx;
  logic               r_memWrite;
  logic [31:0]        r_writeData;
  logic [31:0]        r_dataAdr;
  logic               r_lastWord;
  logic [31:0]        w_wordNext;
  logic               w_wordDone;
  logic               w_isLast;

  assign w_halfDone = (r_bitCnt == c_HALF_LAST);
  assign w_bitDone  = (r_bitCnt == c_BIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rxState <= RX_IDLE;
    end else begin
      r_rxState <= w_rxNext;
    end
  end

  always_comb begin
    w_rxNext      = r_rxState;
    w_cntClr      = 1'b0;
    w_sampleBit   = 1'b0;
    w_byteValid   = 1'b0;
    w_frameErrSet = 1'b0;
    case (r_rxState)
      RX_IDLE: begin
        if (!r_rxSync) begin
          w_rxNext = RX_START;
          w_cntClr = 1'b1;
        end
      end
      RX_START: begin
        // Mid-start-bit check rejects short low glitches on the line.
        if (w_halfDone) begin
          w_cntClr = 1'b1;
          w_rxNext = r_rxSync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_bitDone) begin
          w_cntClr    = 1'b1;
          w_sampleBit = 1'b1;
          if (r_bitIdx == 3'd7) begin
            w_rxNext = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (w_bitDone) begin
          w_cntClr = 1'b1;
          w_rxNext = RX_IDLE;
          if (r_rxSync) begin
            w_byteValid = 1'b1;
          end else begin
            w_frameErrSet = 1'b1;
          end
        end
      end
      default: w_rxNext = RX_IDLE;
    endcase
  end

  // Sync flops reset to the idle-high line level so reset release is not a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rxMeta   <= 1'b1;
      r_rxSync   <= 1'b1;
      r_bitCnt   <= '0;
      r_bitIdx   <= 3'd0;
      r_rxShift  <= 8'd0;
      r_frameErr <= 1'b0;
    end else begin
      r_rxMeta <= rx;
      r_rxSync <= r_rxMeta;
      if (w_cntClr || (r_rxState == RX_IDLE)) begin
        r_bitCnt <= '0;
      end else begin
        r_bitCnt <= r_bitCnt + c_CNT_W'(1);
      end
      if (r_rxState == RX_START) begin
        r_bitIdx <= 3'd0;
      end else if (w_sampleBit) begin
        r_bitIdx <= r_bitIdx + 3'd1;
      end
      if (w_sampleBit) begin
        r_rxShift <= {r_rxSync, r_rxShift[7:1]};
      end
      if (w_frameErrSet) begin
        r_frameErr <= 1'b1;
      end
    end
  end

  assign w_wordNext = {r_rxShift, r_wordShift[31:8]};
  assign w_wordDone = w_byteValid && (r_byteCnt == 2'd3);
  assign w_isLast   = ({2'b00, r_wordIdx} == (r_wordCount - 32'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ldState <= LD_LEN;
    end else begin
      r_ldState <= w_ldNext;
    end
  end

  always_comb begin
    w_ldNext = r_ldState;
    case (r_ldState)
      LD_LEN: begin
        if (w_wordDone) begin
          w_ldNext = (w_wordNext == 32'd0) ? LD_DONE : LD_DATA;
        end
      end
      LD_DATA: begin
        // Leave only after the final strobe so cpu_reset stays high during it.
        if (r_memWrite && r_lastWord) begin
          w_ldNext = LD_DONE;
        end
      end
      LD_DONE: w_ldNext = LD_DONE;
      default: w_ldNext = LD_LEN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_byteCnt   <= 2'd0;
      r_wordShift <= 32'd0;
      r_wordCount <= 32'd0;
      r_wordIdx   <= 30'd0;
      r_memWrite  <= 1'b0;
      r_writeData <= 32'd0;
      r_dataAdr   <= 32'd0;
      r_lastWord  <= 1'b0;
    end else begin
      r_memWrite <= 1'b0;
      if ((r_ldState != LD_DONE) && w_byteValid) begin
        r_byteCnt   <= r_byteCnt + 2'd1;
        r_wordShift <= w_wordNext;
      end
      if ((r_ldState == LD_LEN) && w_wordDone) begin
        r_wordCount <= w_wordNext;
        r_wordIdx   <= 30'd0;
      end
      if ((r_ldState == LD_DATA) && w_wordDone) begin
        r_memWrite  <= 1'b1;
        r_writeData <= w_wordNext;
        r_dataAdr   <= {r_wordIdx, 2'b00};
        r_wordIdx   <= r_wordIdx + 30'd1;
        r_lastWord  <= w_isLast;
      end
    end
  end

  assign Ext_MemWrite  = r_memWrite;
  assign Ext_WriteData = r_writeData;
  assign Ext_DataAdr   = r_dataAdr;
  assign cpu_reset     = (r_ldState != LD_DONE);
  assign load_done     = (r_ldState == LD_DONE);
  assign frame_err     = r_frameErr;

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
// tb_uart_boot_loader : scoreboard bench; a byte-stream model predicts the
//                       memory writes and the CPU release for each stream.
// Revision 1.0
// ============================================================================
module tb_uart_boot_loader;

  localparam int CPB = 8;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        rx    = 1'b1;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;
  logic        cpu_reset;
  logic        load_done;
  logic        frame_err;

  uart_boot_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .Ext_MemWrite (Ext_MemWrite),
    .Ext_WriteData(Ext_WriteData),
    .Ext_DataAdr  (Ext_DataAdr),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          isRel;
    logic [31:0] adr;
    logic [31:0] data;
  } exp_t;

  exp_t        expQ[$];
  logic [7:0]  sb[$];
  bit          sok[$];
  int          errors = 0;
  int          checks = 0;
  int          lastByteBase = 0;
  int          lastStrobe = 0;
  bit          sawStrobe = 1'b0;
  logic        prevDone = 1'b0;
  logic        prevWrite = 1'b0;
  exp_t        mon;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: keep the accepted bytes, read N, then N little-endian words, then release.
  function automatic void modelStream(input logic [7:0] b[$], input bit ok[$]);
    logic [7:0]  acc[$];
    logic [31:0] n;
    exp_t        e;
    foreach (b[i]) if (ok[i]) acc.push_back(b[i]);
    if (acc.size() < 4) return;
    n = {acc[3], acc[2], acc[1], acc[0]};
    for (int w = 0; w < int'(n); w++) begin
      if (acc.size() < 8 + 4 * w) return;
      e.isRel = 1'b0;
      e.adr   = 32'(w * 4);
      e.data  = {acc[7 + 4*w], acc[6 + 4*w], acc[5 + 4*w], acc[4 + 4*w]};
      expQ.push_back(e);
    end
    e.isRel = 1'b1;
    e.adr   = 32'd0;
    e.data  = 32'd0;
    expQ.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (prevWrite) check("strobe_width", 32'(Ext_MemWrite), 32'd0);
      if (Ext_MemWrite && !prevWrite) begin
        if (expQ.size() == 0 || expQ[0].isRel) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got adr 0x%08h data 0x%08h, expected no strobe", Ext_DataAdr, Ext_WriteData);
        end else begin
          mon = expQ.pop_front();
          check("strobe_adr", Ext_DataAdr, mon.adr);
          check("strobe_data", Ext_WriteData, mon.data);
          check("cpu_reset_at_strobe", 32'(cpu_reset), 32'd1);
          check("strobe_in_stop_bit", 32'((cyc - lastByteBase >= 72) && (cyc - lastByteBase <= 82)), 32'd1);
        end
        sawStrobe  = 1'b1;
        lastStrobe = cyc;
      end
      if (load_done && !prevDone) begin
        if (expQ.size() == 0 || !expQ[0].isRel) begin
          checks++;
          errors++;
          $display("FAIL unexpected_release: got load_done=1 with %0d events pending, expected no release", expQ.size());
        end else begin
          mon = expQ.pop_front();
          check("cpu_reset_released", 32'(cpu_reset), 32'd0);
          if (sawStrobe) check("release_after_strobe", 32'(cyc - lastStrobe), 32'd1);
          else check("release_in_stop_bit", 32'((cyc - lastByteBase >= 72) && (cyc - lastByteBase <= 82)), 32'd1);
        end
      end
    end
    prevDone  = load_done;
    prevWrite = Ext_MemWrite;
  end

  task automatic sendByte(input logic [7:0] d, input bit goodStop);
    @(negedge clk);
    lastByteBase = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = goodStop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!goodStop) repeat (2 * CPB) @(negedge clk);
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic addByte(input logic [7:0] d, input bit ok);
    sb.push_back(d);
    sok.push_back(ok);
  endtask

  task automatic addWords(input int n, input bit withErr);
    logic [31:0] nn;
    nn = 32'(n);
    for (int i = 0; i < 4; i++) addByte(nn[8*i +: 8], 1'b1);
    for (int k = 0; k < 4 * n; k++) begin
      logic [7:0] v;
      v = 8'($urandom);
      if (withErr && $urandom_range(0, 5) == 0) addByte(8'($urandom), 1'b0);
      addByte(v, 1'b1);
    end
  endtask

  task automatic runStream();
    bit anyBad;
    anyBad = 1'b0;
    modelStream(sb, sok);
    foreach (sb[i]) begin
      sendByte(sb[i], sok[i]);
      if (!sok[i]) anyBad = 1'b1;
      check("frame_err", 32'(frame_err), 32'(anyBad));
    end
    sb.delete();
    sok.delete();
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 3000 && expQ.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  task automatic doReset();
    @(posedge clk);
    #2 reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    sawStrobe = 1'b0;
    expQ.delete();
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_cpu_reset", 32'(cpu_reset), 32'd1);
    check("reset_memwrite", 32'(Ext_MemWrite), 32'd0);
    check("reset_load_done", 32'(load_done), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_adr", Ext_DataAdr, 32'd0);
    check("reset_data", Ext_WriteData, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (200) @(negedge clk);
    check("idle_load_done", 32'(load_done), 32'd0);
    check("idle_cpu_reset", 32'(cpu_reset), 32'd1);

    // Two-word load, then traffic after completion must be ignored.
    addByte(8'h02, 1'b1); addByte(8'h00, 1'b1); addByte(8'h00, 1'b1); addByte(8'h00, 1'b1);
    addByte(8'hEF, 1'b1); addByte(8'hBE, 1'b1); addByte(8'hAD, 1'b1); addByte(8'hDE, 1'b1);
    addByte(8'h78, 1'b1); addByte(8'h56, 1'b1); addByte(8'h34, 1'b1); addByte(8'h12, 1'b1);
    runStream();
    waitDrain();
    for (int i = 0; i < 4; i++) sendByte(8'($urandom), 1'b1);
    check("done_sticky", 32'(load_done), 32'd1);
    check("done_cpu_reset", 32'(cpu_reset), 32'd0);
    check("hold_adr", Ext_DataAdr, 32'h4);
    check("hold_data", Ext_WriteData, 32'h12345678);

    // Zero word count.
    doReset();
    for (int i = 0; i < 4; i++) addByte(8'h00, 1'b1);
    runStream();
    waitDrain();
    check("zero_load_done", 32'(load_done), 32'd1);

    // Framing error on a data byte, then resent correctly.
    doReset();
    addByte(8'h01, 1'b1); addByte(8'h00, 1'b1); addByte(8'h00, 1'b1); addByte(8'h00, 1'b1);
    addByte(8'hA5, 1'b1); addByte(8'h3C, 1'b0); addByte(8'h3C, 1'b1);
    addByte(8'h96, 1'b1); addByte(8'h0F, 1'b1);
    runStream();
    waitDrain();
    check("ferr_load_done", 32'(load_done), 32'd1);

    // Start-bit glitch, then a valid random stream.
    doReset();
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_frame_err", 32'(frame_err), 32'd0);
    check("glitch_load_done", 32'(load_done), 32'd0);
    addWords($urandom_range(1, 3), 1'b0);
    runStream();
    waitDrain();
    check("glitch_stream_done", 32'(load_done), 32'd1);

    // Abort after two data bytes, then a fresh one-word stream.
    doReset();
    addByte(8'h01, 1'b1); addByte(8'h00, 1'b1); addByte(8'h00, 1'b1); addByte(8'h00, 1'b1);
    addByte(8'hAA, 1'b1); addByte(8'hBB, 1'b1);
    runStream();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
    check("abort_memwrite", 32'(Ext_MemWrite), 32'd0);
    check("abort_adr", Ext_DataAdr, 32'd0);
    check("abort_data", Ext_WriteData, 32'd0);
    check("abort_pending", 32'(expQ.size()), 32'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    sawStrobe = 1'b0;
    addByte(8'h01, 1'b1); addByte(8'h00, 1'b1); addByte(8'h00, 1'b1); addByte(8'h00, 1'b1);
    addByte(8'h44, 1'b1); addByte(8'h33, 1'b1); addByte(8'h22, 1'b1); addByte(8'h11, 1'b1);
    runStream();
    waitDrain();
    check("abort_reload_done", 32'(load_done), 32'd1);

    // Random streams with occasional framing errors.
    for (int r = 0; r < 3; r++) begin
      doReset();
      addWords($urandom_range(1, 4), 1'b1);
      runStream();
      waitDrain();
      check("random_done", 32'(load_done), 32'd1);
    end

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
